// File: rtl/uart_tx_buf_if.sv
// Byte-stream port bundle for uart_tx_buf: upstream write strobe/data plus serial line and FIFO status.
// The master drives bytes in; the slave (the transmitter) reports the line and the buffer state.
interface uart_tx_buf_if #(
    parameter int FIFO_AW = 4
);
    logic               wr;
    logic [7:0]         din;
    logic               txd;
    logic               busy;
    logic               full;
    logic               overflow;
    logic [FIFO_AW:0]   fifo_cnt;

    modport master (
        output wr, din,
        input  txd, busy, full, overflow, fifo_cnt
    );

    modport slave (
        input  wr, din,
        output txd, busy, full, overflow, fifo_cnt
    );
endinterface

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: first start bit one clock after an idle write; writes into a full FIFO are dropped (sticky overflow).
// Optional UART_CRLF_EN: a 0x0D frame is followed by a generated 0x0A frame that takes no FIFO entry.
module uart_tx_buf #(
    parameter int BAUD_DIV = 104,
    parameter int FIFO_AW  = 4
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_buf_if.slave  bus
);
    localparam int               DEPTH     = 1 << FIFO_AW;
    localparam int               BW        = $clog2(BAUD_DIV);
    localparam logic [FIFO_AW:0] DEPTH_C   = (FIFO_AW + 1)'(DEPTH);
    localparam logic [BW-1:0]    BAUD_LAST = BW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_nxt;
    logic [BW-1:0]      baud, baud_nxt;
    logic [2:0]         bit_idx, bit_nxt;
    logic [7:0]         shift, shift_nxt;
    logic [FIFO_AW-1:0] rd_ptr, wr_ptr;
    logic [FIFO_AW:0]   cnt, cnt_nxt;
    logic [7:0]         mem [DEPTH];
    logic               txd_q, busy_q, full_q, ovf_q;
    logic               baud_end, not_empty, is_full, push, pop, load;
    logic [7:0]         head;
`ifdef UART_CRLF_EN
    logic               cr_q, cr_nxt;
`endif

    assign baud_end  = (baud == BAUD_LAST);
    assign not_empty = (cnt != '0);
    assign is_full   = (cnt == DEPTH_C);
    assign push      = bus.wr && !is_full;
    assign head      = mem[rd_ptr];

    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_end ? '0 : baud + BW'(1);
        bit_nxt   = bit_idx;
        shift_nxt = shift;
        pop       = 1'b0;
        load      = 1'b0;
`ifdef UART_CRLF_EN
        cr_nxt    = cr_q;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (not_empty) begin
                    load      = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_end) state_nxt = DATA;
            end
            DATA: begin
                if (baud_end) begin
                    shift_nxt = {1'b0, shift[7:1]};
                    bit_nxt   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (baud_end) begin
`ifdef UART_CRLF_EN
                    // The LF frame goes out before the FIFO is looked at again.
                    if (cr_q) begin
                        shift_nxt = 8'h0A;
                        bit_nxt   = 3'd0;
                        cr_nxt    = 1'b0;
                        state_nxt = START;
                    end else if (not_empty) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
`else
                    if (not_empty) begin
                        load      = 1'b1;
                        state_nxt = START;
                    end else begin
                        state_nxt = IDLE;
                    end
`endif
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            shift_nxt = head;
            pop       = 1'b1;
            bit_nxt   = 3'd0;
            baud_nxt  = '0;
`ifdef UART_CRLF_EN
            cr_nxt    = (head == 8'h0D);
`endif
        end

        case ({push, pop})
            2'b10:   cnt_nxt = cnt + 1'b1;
            2'b01:   cnt_nxt = cnt - 1'b1;
            default: cnt_nxt = cnt;
        endcase
    end

    // Outputs are registered from next-state so the line moves on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= 3'd0;
            shift   <= 8'h00;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            cnt     <= '0;
            txd_q   <= 1'b1;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef UART_CRLF_EN
            cr_q    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            baud    <= baud_nxt;
            bit_idx <= bit_nxt;
            shift   <= shift_nxt;
            cnt     <= cnt_nxt;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            txd_q   <= (state_nxt == START) ? 1'b0 :
                       (state_nxt == DATA)  ? shift_nxt[0] : 1'b1;
            busy_q  <= (state_nxt != IDLE) || (cnt_nxt != '0);
            full_q  <= (cnt_nxt == DEPTH_C);
            ovf_q   <= ovf_q || (bus.wr && is_full);
`ifdef UART_CRLF_EN
            cr_q    <= cr_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.din;
    end

    assign bus.txd      = txd_q;
    assign bus.busy     = busy_q;
    assign bus.full     = full_q;
    assign bus.overflow = ovf_q;
    assign bus.fifo_cnt = cnt;
endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf at BAUD_DIV=4, depth 16; a line decoder rebuilds frames from txd.
module tb_uart_tx_buf;
    localparam int BD = 4;
    localparam int AW = 4;
    localparam int FIRST = BD + BD / 2;
    localparam int STOPT = 9 * BD + BD / 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    uart_tx_buf_if #(.FIFO_AW(AW)) bus ();

    uart_tx_buf #(.BAUD_DIV(BD), .FIFO_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int chk_cnt = 0;
    int fail_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Line decoder: samples each bit at its centre, counted from the start-bit edge.
    int         cyc = 0;
    logic       rx_busy = 1'b0;
    int         rx_t = 0;
    int         rx_start = 0;
    logic [7:0] rx_byte = 8'h00;
    logic [7:0] rx_q[$];
    int         st_q[$];
    int         rt;
    assign rt = rx_t + 1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!rst) begin
            rx_busy <= 1'b0;
        end else if (!rx_busy) begin
            if (!bus.txd) begin
                rx_busy  <= 1'b1;
                rx_t     <= 0;
                rx_start <= cyc;
            end
        end else begin
            rx_t <= rt;
            if (rt >= FIRST && rt <= FIRST + 7 * BD && ((rt - FIRST) % BD) == 0)
                rx_byte[3'((rt - FIRST) / BD)] <= bus.txd;
            if (rt == STOPT) begin
                check("stop_bit", {31'd0, bus.txd}, 32'd1);
                rx_q.push_back(rx_byte);
                st_q.push_back(rx_start);
                rx_busy <= 1'b0;
            end
        end
    end

    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        st_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        clear_rx();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (bus.busy && n < 3000) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, {31'd0, bus.busy}, 32'd0);
        repeat (6) tick();
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_frames"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
        for (int i = 1; i < st_q.size(); i++)
            check($sformatf("%s_gap%0d", tag, i), st_q[i] - st_q[i-1], 10 * BD);
    endtask

    task automatic write1(input logic [7:0] b);
        bus.wr  = 1'b1;
        bus.din = b;
        tick();
        bus.wr  = 1'b0;
    endtask

    logic [9:0] frame;
    logic [7:0] burst [8];
    int         peak;

    initial begin
        bus.wr  = 1'b0;
        bus.din = 8'h00;
        burst = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h50, 8'h4D, 8'h0D};

        // Reset values
        rst = 1'b0;
        repeat (3) tick();
        check("rst_txd",  {31'd0, bus.txd}, 32'd1);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_full", {31'd0, bus.full}, 32'd0);
        check("rst_ovf",  {31'd0, bus.overflow}, 32'd0);
        check("rst_cnt",  {27'd0, bus.fifo_cnt}, 32'd0);
        rst = 1'b1;
        tick();
        clear_rx();

        // Single byte 0x41: line pattern 0,1,0,0,0,0,0,1,0,1, four clocks per bit
        frame = 10'b1010000010;
        write1(8'h41);
        check("single_cnt", {27'd0, bus.fifo_cnt}, 32'd1);
        for (int k = 1; k <= 41; k++) begin
            tick();
            if (k % BD == 1 && k <= 37)
                check($sformatf("single_bit%0d", (k - 1) / BD), {31'd0, bus.txd}, {31'd0, frame[(k - 1) / BD]});
            if (k == 40) check("single_busy_e40", {31'd0, bus.busy}, 32'd1);
            if (k == 41) check("single_busy_e41", {31'd0, bus.busy}, 32'd0);
        end
        repeat (4) tick();
        exp_q.push_back(8'h41);
        check_rx("single");

        // Upstream burst "12:34PM" + CR, one byte every 2 clocks
        clear_rx();
        peak = 0;
        for (int i = 0; i < 8; i++) begin
            write1(burst[i]);
            if (int'(bus.fifo_cnt) > peak) peak = int'(bus.fifo_cnt);
            tick();
            exp_q.push_back(burst[i]);
        end
`ifdef UART_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        check("burst_peak", peak, 7);
        drain("burst");
        check("burst_ovf", {31'd0, bus.overflow}, 32'd0);
        check_rx("burst");

        // 18 writes on consecutive edges: 17 accepted, 18th dropped
        do_reset();
        bus.wr = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bus.din = 8'h60 + 8'(i);
            tick();
            if (i == 15) check("ovf_full_16th", {31'd0, bus.full}, 32'd0);
            if (i == 16) begin
                check("ovf_full_17th", {31'd0, bus.full}, 32'd1);
                check("ovf_ovf_17th", {31'd0, bus.overflow}, 32'd0);
            end
            if (i < 17) exp_q.push_back(8'h60 + 8'(i));
        end
        bus.wr = 1'b0;
        check("ovf_set", {31'd0, bus.overflow}, 32'd1);
        check("ovf_cnt", {27'd0, bus.fifo_cnt}, 32'd16);
        drain("ovf");
        check("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
        check_rx("ovf");

        // Write coincides with a pop while count is 16
        do_reset();
        bus.wr = 1'b1;
        for (int i = 0; i < 17; i++) begin
            bus.din = 8'h20 + 8'(i);
            tick();
        end
        bus.wr = 1'b0;
        repeat (24) tick();
        check("simul_pre_full", {31'd0, bus.full}, 32'd1);
        check("simul_pre_ovf", {31'd0, bus.overflow}, 32'd0);
        write1(8'hEE);
        check("simul_cnt", {27'd0, bus.fifo_cnt}, 32'd15);
        check("simul_ovf", {31'd0, bus.overflow}, 32'd1);
        check("simul_full", {31'd0, bus.full}, 32'd0);

        // Reset during DATA bit 3 with 5 bytes queued
        do_reset();
        bus.wr = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.din = (i == 0) ? 8'hF7 : 8'h10 + 8'(i);
            tick();
        end
        bus.wr = 1'b0;
        repeat (13) tick();
        check("rstmid_bit3", {31'd0, bus.txd}, 32'd0);
        check("rstmid_cnt_pre", {27'd0, bus.fifo_cnt}, 32'd5);
        rst = 1'b0;
        tick();
        check("rstmid_txd", {31'd0, bus.txd}, 32'd1);
        check("rstmid_cnt", {27'd0, bus.fifo_cnt}, 32'd0);
        check("rstmid_busy", {31'd0, bus.busy}, 32'd0);
        rst = 1'b1;
        tick();
        clear_rx();
        write1(8'h55);
        exp_q.push_back(8'h55);
        drain("rstmid");
        check_rx("rstmid");

        // CR followed by 'A'
        clear_rx();
        write1(8'h0D);
        write1(8'h41);
        exp_q.push_back(8'h0D);
`ifdef UART_CRLF_EN
        exp_q.push_back(8'h0A);
`endif
        exp_q.push_back(8'h41);
        drain("crlf");
        check_rx("crlf");

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/uart_tx_buf.md
# uart_tx_buf

Buffered 8N1 UART transmitter that consumes the byte stream produced by the string-display stage (`rdy` pulse plus `dOut` byte) and drives the iCEstick serial TX pin. The upstream stage emits a byte every 2 clocks, far faster than the line rate. This block therefore holds a small FIFO that absorbs a full 8-byte burst (7 characters plus CR) and drains it at the baud rate. It sits between the display formatter and the top-level `txd` pin.

## Interface

- `BAUD_DIV`, default 104: clocks per bit (12 MHz / 115200); legal range 2..4095.
- `FIFO_AW`, default 4: FIFO address width; depth = 2^FIFO_AW (16).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `wr`  in  1  write strobe; connect to upstream `rdy`.
- `din`  in  8  byte to enqueue, sampled on a rising edge where `wr`=1.
- `txd`  out  1  serial line; idles high.
- `busy`  out  1  high while a frame is in progress or the FIFO is non-empty.
- `full`  out  1  FIFO count == depth.
- `overflow`  out  1  sticky; a write was dropped.
- `fifo_cnt`  out  FIFO_AW+1  current FIFO occupancy.

## Operation

- FIFO: circular buffer with registered read/write pointers and count. A write with `full`=0 stores `din` and increments the count. A write with `full`=1 is dropped and sets `overflow`.
- `full` and the empty condition come from the registered count before the edge. A write and a pop on the same edge leave the count unchanged. A write while full is dropped even if a pop occurs on that edge.
- A byte written on edge E is not poppable before edge E+1.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO non-empty, load the head byte into the shift register, pop, clear the baud counter and bit index, and go to START.
  - START: `txd`=0 for BAUD_DIV cycles, then go to DATA.
  - DATA: `txd`=shift[0], LSB first. Shift every BAUD_DIV cycles. After 8 bits go to STOP.
  - STOP: `txd`=1 for BAUD_DIV cycles. At the end, if FIFO non-empty, pop and go directly to START with no idle gap. Otherwise go to IDLE.
- Baud counter: counts 0..BAUD_DIV-1 and wraps, restarting at each state entry.
- `busy` = (state != IDLE) | (count != 0).
- Reset mid-frame: all state is abandoned. FIFO is emptied and `txd` returns to 1 on the reset edge, with no partial stop bit.
- Reset values: `txd`=1, `busy`=0, `full`=0, `overflow`=0, `fifo_cnt`=0, state=IDLE. `overflow` clears only on reset.

## Timing

- All outputs are registered.
- With FIFO empty and IDLE, `wr` sampled at edge E0 gives `txd`=0 from edge E1.
- Frame = 10·BAUD_DIV cycles. Back-to-back frames are contiguous.
- `fifo_cnt` and `full` update on the edge that performs the write or pop.
- Minimum accepted burst: 2^FIFO_AW writes at any rate, plus 1 if the first write finds the FSM idle.

## Configuration

- `UART_CRLF_EN`
  - Defined: after the STOP of any frame whose byte was 0x0D, the FSM sends one extra frame with byte 0x0A before checking the FIFO. This frame does not consume a FIFO entry, and `busy` stays high through it.
  - Undefined: 0x0D is sent like any other byte and no extra frame is generated.

## Test plan

- Single byte, BAUD_DIV=4: write 0x41 while idle -> from E1, `txd` = 0,1,0,0,0,0,0,1,0,1 with each bit 4 cycles wide. `busy` falls at E41.
- Upstream burst: 7 bytes "12:34PM" then 0x0D, one every 2 cycles -> all 8 frames sent in order, contiguous, peak `fifo_cnt`=7, `overflow`=0.
- Overflow, depth 16: 18 writes on consecutive edges while idle -> bytes 1..17 transmitted, 18th dropped, `full`=1 at the 17th write edge, `overflow`=1 and stays 1 after the FIFO drains.
- Reset mid-frame: assert `rst`=0 during DATA bit 3 with 5 bytes queued -> on that edge `txd`=1, `fifo_cnt`=0, `busy`=0. A new write after release starts a clean frame.
- With `UART_CRLF_EN`: send 0x0D, 0x41 -> frames 0x0D, 0x0A, 0x41 back-to-back. Without the macro -> frames 0x0D, 0x41 only.
- Simultaneous write and pop at count 16 -> write dropped, count 15, `overflow`=1.
